// File: rtl/rr_arb_mux_8_64bit_if.sv
// Bus bundle for the 8-way round-robin arbiter/mux: requester side inputs and
// granted-word outputs. The master modport is the requester/consumer side.
interface rr_arb_mux_8_64bit_if;
  logic [7:0]   req;
  logic [511:0] in_data;
  logic         out_ready;
  logic         out_valid;
  logic [63:0]  out_data;
  logic [2:0]   sel;
  logic [7:0]   gnt;
  logic [7:0]   ack;
  logic [15:0]  xfer_cnt;

  modport master (
    output req, in_data, out_ready,
    input  out_valid, out_data, sel, gnt, ack, xfer_cnt
  );

  modport slave (
    input  req, in_data, out_ready,
    output out_valid, out_data, sel, gnt, ack, xfer_cnt
  );
endinterface

// File: rtl/rr_arb_mux_8_64bit.sv
// 8-requester arbiter with registered 64-bit output word and transfer counter.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module rr_arb_mux_8_64bit (
  input  logic                 clk,
  input  logic                 rst,
  rr_arb_mux_8_64bit_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [63:0] data_p1;
  logic [2:0]  sel_p1;
  logic [7:0]  gnt_p1;
  logic [15:0] cnt_p1;
  logic        hs;
  logic        go;
  logic [7:0]  cand;
  logic [2:0]  base;
  logic [2:0]  win;
`ifndef ARB_FIXED_PRIO_EN
  logic [2:0]  ptr_p1;
`endif

  // First set bit of cand scanning upward from base, wrapping 7 -> 0.
  function automatic logic [2:0] pick(input logic [7:0] c, input logic [2:0] b);
    logic [2:0] idx;
    logic [2:0] res;
    logic       hit;
    res = b;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = b + 3'(i);
      if (!hit && c[idx]) begin
        res = idx;
        hit = 1'b1;
      end
    end
    return res;
  endfunction

  // At a handshake the current winner is masked out so a held request cannot
  // win twice in a row; while stalled nothing is eligible.
  always_comb begin
    hs   = (state == BUSY) && bus.out_ready;
    cand = 8'h00;
    if (state == IDLE)
      cand = bus.req;
    else if (hs)
      cand = bus.req & ~gnt_p1;
    go = |cand;
`ifdef ARB_FIXED_PRIO_EN
    base = 3'd0;
`else
    base = hs ? sel_p1 + 3'd1 : ptr_p1;
`endif
    win = pick(cand, base);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (go) state_nxt = BUSY;
      BUSY: if (hs && !go) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = (state == BUSY);
    bus.out_data  = data_p1;
    bus.sel       = sel_p1;
    bus.gnt       = gnt_p1;
    bus.ack       = gnt_p1 & {8{bus.out_ready}};
    bus.xfer_cnt  = cnt_p1;
  end

  // Grant/capture stage: output word and grant registered one cycle after arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p1 <= 64'h0;
      sel_p1  <= 3'd0;
      gnt_p1  <= 8'h00;
      cnt_p1  <= 16'h0000;
`ifndef ARB_FIXED_PRIO_EN
      ptr_p1  <= 3'd0;
`endif
    end else begin
      if (hs) begin
        cnt_p1 <= cnt_p1 + 16'd1;
`ifndef ARB_FIXED_PRIO_EN
        ptr_p1 <= sel_p1 + 3'd1;
`endif
      end
      if (go) begin
        sel_p1  <= win;
        gnt_p1  <= 8'h01 << win;
        data_p1 <= bus.in_data[{win, 6'b0} +: 64];
      end else if (hs) begin
        gnt_p1  <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux_8_64bit.sv
// Self-checking bench for rr_arb_mux_8_64bit: vector table, directed corner
// sequences and randomized traffic against a behavioural arbitration model.
module tb_rr_arb_mux_8_64bit;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rr_arb_mux_8_64bit_if bus();

  rr_arb_mux_8_64bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit quiet  = 1'b0;

  // Behavioural model state
  bit          m_busy;
  int          m_sel;
  int          m_ptr;
  logic [15:0] m_cnt;
  logic [63:0] m_data;

  logic [511:0] kd;

  typedef struct {
    logic [7:0]  req;
    bit          rdy;
    logic [7:0]  ack;
    bit          valid;
    logic [2:0]  sel;
    logic [7:0]  gnt;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] slice_pat(input int k);
    logic [3:0] nib;
    nib = 4'(k);
    return {16{nib}};
  endfunction

  function automatic logic [511:0] k_data();
    logic [511:0] d;
    for (int k = 0; k < 8; k++) d[k*64 +: 64] = slice_pat(k);
    return d;
  endfunction

  function automatic logic [511:0] rnd_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [7:0] m_gnt();
    return m_busy ? 8'(1 << m_sel) : 8'h00;
  endfunction

  function automatic int pick(input logic [7:0] c, input int b);
    for (int i = 0; i < 8; i++)
      if (c[(b + i) % 8]) return (b + i) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_ptr  = 0;
    m_cnt  = 16'h0000;
    m_data = 64'h0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic [511:0] d, input bit rdy);
    bit         hs;
    logic [7:0] c;
    int         w;
    hs = m_busy && rdy;
    if (hs) begin
      m_cnt = m_cnt + 16'd1;
      m_ptr = (m_sel + 1) % 8;
      c = r & ~m_gnt();
    end else if (!m_busy) begin
      c = r;
    end else begin
      c = 8'h00;
    end
    if (c != 8'h00) begin
      w      = pick(c, FIXED ? 0 : m_ptr);
      m_sel  = w;
      m_data = d[w*64 +: 64];
      m_busy = 1'b1;
    end else if (hs) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic compare_outputs();
    chk("out_valid", 64'(bus.out_valid), 64'(m_busy));
    chk("sel", 64'(bus.sel), 64'(m_sel));
    chk("gnt", 64'(bus.gnt), 64'(m_gnt()));
    chk("xfer_cnt", 64'(bus.xfer_cnt), 64'(m_cnt));
    chk("out_data", bus.out_data, m_data);
    chk("gnt_onehot", 64'($onehot0(bus.gnt)), 64'd1);
  endtask

  // Called at posedge+1 (or later, before the next edge); returns at posedge+1.
  task automatic cycle(input logic [7:0] r, input logic [511:0] d, input bit rdy);
    bus.req       = r;
    bus.in_data   = d;
    bus.out_ready = rdy;
    #1;
    if (!quiet) chk("ack", 64'(bus.ack), 64'(m_gnt() & {8{rdy}}));
    @(posedge clk);
    model_step(r, d, rdy);
    #1;
    if (!quiet) compare_outputs();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req       = 8'h00;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_cnt", 64'(bus.xfer_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    compare_outputs();
  endtask

  initial begin
    logic [7:0] r;
    bit         rdy;
    kd = k_data();

    // Vector table (identical in both arbitration builds)
    tbl[0] = '{8'h04, 1'b1, 8'h00, 1'b1, 3'd2, 8'h04, 16'd0};
    tbl[1] = '{8'h00, 1'b1, 8'h04, 1'b0, 3'd2, 8'h00, 16'd1};
    tbl[2] = '{8'h00, 1'b0, 8'h00, 1'b0, 3'd2, 8'h00, 16'd1};
    tbl[3] = '{8'h10, 1'b0, 8'h00, 1'b1, 3'd4, 8'h10, 16'd1};
    tbl[4] = '{8'h10, 1'b0, 8'h00, 1'b1, 3'd4, 8'h10, 16'd1};
    tbl[5] = '{8'h11, 1'b1, 8'h10, 1'b1, 3'd0, 8'h01, 16'd2};
    tbl[6] = '{8'h00, 1'b1, 8'h01, 1'b0, 3'd0, 8'h00, 16'd3};
    tbl[7] = '{8'h40, 1'b1, 8'h00, 1'b1, 3'd6, 8'h40, 16'd3};
    tbl[8] = '{8'h40, 1'b1, 8'h40, 1'b0, 3'd6, 8'h00, 16'd4};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.req       = tbl[i].req;
      bus.in_data   = kd;
      bus.out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_ack", i), 64'(bus.ack), 64'(tbl[i].ack));
      @(posedge clk);
      model_step(tbl[i].req, kd, tbl[i].rdy);
      #1;
      chk($sformatf("tbl%0d_valid", i), 64'(bus.out_valid), 64'(tbl[i].valid));
      chk($sformatf("tbl%0d_sel", i), 64'(bus.sel), 64'(tbl[i].sel));
      chk($sformatf("tbl%0d_gnt", i), 64'(bus.gnt), 64'(tbl[i].gnt));
      chk($sformatf("tbl%0d_cnt", i), 64'(bus.xfer_cnt), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_data", i), bus.out_data, slice_pat(int'(tbl[i].sel)));
    end

    // All requesters held: rotation with no bubble
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(8'hFF, kd, 1'b1);
      chk($sformatf("rot%0d_sel", i), 64'(bus.sel), 64'(FIXED ? i % 2 : i % 8));
      chk($sformatf("rot%0d_valid", i), 64'(bus.out_valid), 64'd1);
    end

    // Stall on requester 5 while inputs churn
    do_reset();
    cycle(8'h20, kd, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(8'($urandom), rnd_data(), 1'b0);
      chk($sformatf("stall%0d_sel", i), 64'(bus.sel), 64'd5);
      chk($sformatf("stall%0d_data", i), bus.out_data, slice_pat(5));
    end
    cycle(8'($urandom), rnd_data(), 1'b1);
    chk("stall_hs_cnt", 64'(bus.xfer_cnt), 64'd1);

    // Asynchronous reset in the middle of a BUSY transfer
    do_reset();
    cycle(8'h08, kd, 1'b1);
    cycle(8'h08, kd, 1'b1);
    cycle(8'h08, kd, 1'b0);
    chk("pre_rst_sel", 64'(bus.sel), 64'd3);
    chk("pre_rst_cnt", 64'(bus.xfer_cnt), 64'd1);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_gnt", 64'(bus.gnt), 64'd0);
    chk("arst_ack", 64'(bus.ack), 64'd0);
    chk("arst_cnt", 64'(bus.xfer_cnt), 64'd0);
    chk("arst_sel", 64'(bus.sel), 64'd0);
    rst = 1'b0;
    model_reset();
    cycle(8'h88, kd, 1'b0);
    chk("post_rst_sel", 64'(bus.sel), 64'd3);
    chk("post_rst_gnt", 64'(bus.gnt), 64'h08);

    // Pointer at 1 with requests 0 and 7
    do_reset();
    cycle(8'h01, kd, 1'b1);
    cycle(8'h00, kd, 1'b1);
    cycle(8'h81, kd, 1'b1);
    chk("p1_first_sel", 64'(bus.sel), 64'(FIXED ? 0 : 7));
    cycle(8'h81, kd, 1'b1);
    chk("p1_second_sel", 64'(bus.sel), 64'(FIXED ? 7 : 0));

    // Randomized traffic, with occasional reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) do_reset();
      r   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      cycle(r, rnd_data(), rdy);
    end

    // Counter wrap: 65535 handshakes then one more
    do_reset();
    quiet = 1'b1;
    for (int i = 0; i < 65536; i++) cycle(8'hFF, kd, 1'b1);
    quiet = 1'b0;
    chk("cnt_ffff", 64'(bus.xfer_cnt), 64'hFFFF);
    cycle(8'hFF, kd, 1'b1);
    chk("cnt_wrap", 64'(bus.xfer_cnt), 64'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
